// File: rtl/iq_capture_buffer.sv
// Captures the decimated baseband I/Q stream into block RAM after an arm command,
// optionally gated by a magnitude trigger, with a registered random-access readback port.
module iq_capture_buffer #(
  parameter int DW   = 16,
  parameter int AW   = 10,
  parameter int DECW = 8
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              in_ce,
  input  logic [DW-1:0]     in_x,
  input  logic [DW-1:0]     in_y,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig_mode,
  input  logic [DW-1:0]     trig_level,
  input  logic [DECW-1:0]   decim,
  input  logic [AW:0]       length,
  input  logic [AW-1:0]     rd_addr,
  output logic [2*DW-1:0]   rd_data,
  output logic              busy,
  output logic              done,
  output logic [AW:0]       wr_count,
  output logic [1:0]        state
);

  localparam int DEPTH = 2**AW;

  localparam logic [1:0] ST_IDLE      = 2'b00;
  localparam logic [1:0] ST_WAIT_TRIG = 2'b01;
  localparam logic [1:0] ST_CAPTURE   = 2'b10;
  localparam logic [1:0] ST_DONE      = 2'b11;

  localparam logic [AW:0]   DEPTH_W  = {1'b1, {AW{1'b0}}};
  localparam logic [DW-1:0] MAX_POS  = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};

  logic [2*DW-1:0] mem [DEPTH];

  logic [AW:0]     len_q;
  logic [DECW-1:0] decim_q;
  logic            trig_mode_q;
  logic [DECW-1:0] dec_cnt;

  logic [DW-1:0]   abs_x;
  logic            trig_hit;
  logic            trig_write;
  logic            cap_write;
  logic            we;
  logic [AW-1:0]   wr_addr;
  logic [AW:0]     wr_next;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    abs_x = in_x;
    if (in_x == MOST_NEG) begin
      abs_x = MAX_POS;
    end else if (in_x[DW-1]) begin
      abs_x = -in_x;
    end
  end

  assign trig_hit   = !trig_mode_q || (abs_x >= trig_level);
  assign trig_write = (state == ST_WAIT_TRIG) && in_ce && trig_hit;
  assign cap_write  = (state == ST_CAPTURE) && in_ce && (dec_cnt == '0);
  assign we         = !abort && !arm && (trig_write || cap_write);
  // In CAPTURE wr_count < len_q <= DEPTH, so the low AW bits are the full address.
  assign wr_addr    = trig_write ? '0 : wr_count[AW-1:0];
  assign wr_next    = wr_count + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      wr_count    <= '0;
      dec_cnt     <= '0;
      len_q       <= DEPTH_W;
      decim_q     <= '0;
      trig_mode_q <= 1'b0;
    end else if (abort) begin
      state <= ST_IDLE;
    end else if (arm) begin
      state       <= ST_WAIT_TRIG;
      wr_count    <= '0;
      len_q       <= ((length == '0) || (length > DEPTH_W)) ? DEPTH_W : length;
      decim_q     <= decim;
      trig_mode_q <= trig_mode;
    end else begin
      case (state)
        ST_WAIT_TRIG: begin
          if (in_ce && trig_hit) begin
            wr_count <= {{AW{1'b0}}, 1'b1};
            dec_cnt  <= decim_q;
            state    <= (len_q == {{AW{1'b0}}, 1'b1}) ? ST_DONE : ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (in_ce) begin
            if (dec_cnt == '0) begin
              wr_count <= wr_next;
              dec_cnt  <= decim_q;
              if (wr_next == len_q) state <= ST_DONE;
            end else begin
              dec_cnt <= dec_cnt - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the sample RAM is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge sys_clk) begin
    if (we) mem[wr_addr] <= {in_x, in_y};
  end

  // Read-during-write to the same address returns the old word.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

  assign busy = (state == ST_WAIT_TRIG) || (state == ST_CAPTURE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_iq_capture_buffer.sv
// Scenario-driven bench for iq_capture_buffer: expected RAM words are queued as
// stimulus is driven and popped during readback sweeps.
module tb_iq_capture_buffer;

  localparam int DW   = 16;
  localparam int AW   = 4;
  localparam int DECW = 8;

  logic            sys_clk = 1'b0;
  logic            rst;
  logic            in_ce;
  logic [DW-1:0]   in_x, in_y;
  logic            arm, abort, trig_mode;
  logic [DW-1:0]   trig_level;
  logic [DECW-1:0] decim;
  logic [AW:0]     length;
  logic [AW-1:0]   rd_addr;
  logic [2*DW-1:0] rd_data;
  logic            busy, done;
  logic [AW:0]     wr_count;
  logic [1:0]      state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2*DW-1:0] exp_q [$];

  iq_capture_buffer #(.DW(DW), .AW(AW), .DECW(DECW)) dut (
    .sys_clk(sys_clk), .rst(rst), .in_ce(in_ce), .in_x(in_x), .in_y(in_y),
    .arm(arm), .abort(abort), .trig_mode(trig_mode), .trig_level(trig_level),
    .decim(decim), .length(length), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .wr_count(wr_count), .state(state)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach summary");
    $fatal(1);
  end

  // wr_count (and with it the write address) must never pass DEPTH.
  always @(negedge sys_clk) begin
    if (rst === 1'b0) begin
      n_cmp++;
      if (wr_count > 5'd16) begin
        n_bad++;
        $display("FAIL wr_count_bound: got %0d, required <= 16", wr_count);
      end
    end
  end

  function automatic logic [2*DW-1:0] word(input logic [DW-1:0] x);
    return {x, x ^ 16'h5A5A};
  endfunction

  // One clock: drive at negedge, let the posedge sample, drop pulses 1 after the edge.
  task automatic cyc(input logic ce, input logic [DW-1:0] x, input logic a, input logic ab);
    @(negedge sys_clk);
    in_ce = ce; in_x = x; in_y = x ^ 16'h5A5A; arm = a; abort = ab;
    @(posedge sys_clk); #1;
    in_ce = 1'b0; arm = 1'b0; abort = 1'b0;
  endtask

  // Arm with a triggerable strobe on the same cycle; that strobe must be ignored.
  task automatic do_arm(input logic mode, input logic [DW-1:0] lvl,
                        input logic [DECW-1:0] dec, input logic [AW:0] len);
    @(negedge sys_clk);
    trig_mode = mode; trig_level = lvl; decim = dec; length = len;
    in_ce = 1'b1; in_x = 16'h7777; in_y = 16'h7777 ^ 16'h5A5A; arm = 1'b1; abort = 1'b0;
    @(posedge sys_clk); #1;
    in_ce = 1'b0; arm = 1'b0;
  endtask

  task automatic readback(input int n, input string tag);
    logic [2*DW-1:0] exp;
    @(negedge sys_clk);
    rd_addr = '0;
    @(posedge sys_clk); #1;
    for (int i = 0; i < n; i++) begin
      rd_addr = AW'(i + 1);
      #1;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL %s_queue: scoreboard empty at addr %0d", tag, i);
      end else begin
        exp = exp_q.pop_front();
        if (rd_data !== exp) begin
          n_bad++;
          $display("FAIL %s_rd[%0d]: got %h, required %h", tag, i, rd_data, exp);
        end
      end
      @(posedge sys_clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_ce = 0; in_x = 0; in_y = 0; arm = 0; abort = 0;
    trig_mode = 0; trig_level = 0; decim = 0; length = 0; rd_addr = 0;
    repeat (3) @(negedge sys_clk);
    n_cmp++;
    if ({state, busy, done, wr_count, rd_data} !== {2'b00, 1'b0, 1'b0, 5'd0, 32'd0}) begin
      n_bad++;
      $display("FAIL reset: got state=%b busy=%b done=%b wr=%0d rd=%h, required 00/0/0/0/0",
               state, busy, done, wr_count, rd_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_immediate;
    do_arm(1'b0, 16'd0, 8'd0, 5'd8);
    n_cmp++;
    if (state !== 2'b01 || busy !== 1'b1) begin
      n_bad++; $display("FAIL imm_armed: got state=%b busy=%b, required 01/1", state, busy);
    end
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, DW'(i), 1'b0, 1'b0);
      if (i < 8) exp_q.push_back(word(DW'(i)));
      if (i == 6) begin
        n_cmp++;
        if (state !== 2'b10 || wr_count !== 5'd7) begin
          n_bad++; $display("FAIL imm_mid: got state=%b wr=%0d, required 10/7", state, wr_count);
        end
      end
    end
    n_cmp++;
    if ({state, done, busy, wr_count} !== {2'b11, 1'b1, 1'b0, 5'd8}) begin
      n_bad++;
      $display("FAIL imm_done: got state=%b done=%b busy=%b wr=%0d, required 11/1/0/8",
               state, done, busy, wr_count);
    end
    readback(8, "imm");
  endtask

  task automatic test_trigger_level;
    do_arm(1'b1, 16'd1000, 8'd0, 5'd8);
    n_cmp++;
    if (wr_count !== 5'd0 || done !== 1'b0) begin
      n_bad++; $display("FAIL trig_rearm: got wr=%0d done=%b, required 0/0", wr_count, done);
    end
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'd999, 1'b0, 1'b0);
    cyc(1'b1, 16'hFC19, 1'b0, 1'b0);  // -999
    n_cmp++;
    if (state !== 2'b01 || wr_count !== 5'd0) begin
      n_bad++; $display("FAIL trig_below: got state=%b wr=%0d, required 01/0", state, wr_count);
    end
    cyc(1'b1, 16'd1000, 1'b0, 1'b0);
    exp_q.push_back(word(16'd1000));
    n_cmp++;
    if (state !== 2'b10 || wr_count !== 5'd1) begin
      n_bad++; $display("FAIL trig_hit: got state=%b wr=%0d, required 10/1", state, wr_count);
    end
    cyc(1'b0, 16'd0, 1'b0, 1'b1);
    readback(1, "trig");
  endtask

  task automatic test_saturated_trigger;
    do_arm(1'b1, 16'd32767, 8'd0, 5'd1);
    cyc(1'b1, 16'd100, 1'b0, 1'b0);
    cyc(1'b1, 16'h8001, 1'b0, 1'b0);  // |x| = 32767 also meets the level
    exp_q.push_back(word(16'h8001));
    n_cmp++;
    if (state !== 2'b11 || wr_count !== 5'd1) begin
      n_bad++; $display("FAIL sat_len1: got state=%b wr=%0d, required 11/1", state, wr_count);
    end
    readback(1, "sat_a");
    do_arm(1'b1, 16'd32767, 8'd0, 5'd1);
    cyc(1'b1, 16'd32766, 1'b0, 1'b0);
    cyc(1'b1, 16'h8000, 1'b0, 1'b0);
    exp_q.push_back(word(16'h8000));
    n_cmp++;
    if (state !== 2'b11 || wr_count !== 5'd1) begin
      n_bad++; $display("FAIL sat_neg: got state=%b wr=%0d, required 11/1", state, wr_count);
    end
    readback(1, "sat_b");
  endtask

  task automatic test_decimation;
    do_arm(1'b0, 16'd0, 8'd3, 5'd4);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, DW'(i), 1'b0, 1'b0);
      if (i % 4 == 0 && i <= 12) exp_q.push_back(word(DW'(i)));
      if (i == 11) begin
        n_cmp++;
        if (state !== 2'b10 || wr_count !== 5'd3) begin
          n_bad++; $display("FAIL dec_pre: got state=%b wr=%0d, required 10/3", state, wr_count);
        end
      end
      if (i == 12) begin
        n_cmp++;
        if (state !== 2'b11 || wr_count !== 5'd4) begin
          n_bad++; $display("FAIL dec_done: got state=%b wr=%0d, required 11/4", state, wr_count);
        end
      end
      cyc(1'b0, 16'd0, 1'b0, 1'b0);
    end
    readback(4, "dec");
  endtask

  task automatic test_abort;
    do_arm(1'b0, 16'd0, 8'd0, 5'd16);
    for (int i = 0; i < 5; i++) cyc(1'b1, DW'(16'h0200 + i), 1'b0, 1'b0);
    n_cmp++;
    if (state !== 2'b10 || wr_count !== 5'd5) begin
      n_bad++; $display("FAIL abort_pre: got state=%b wr=%0d, required 10/5", state, wr_count);
    end
    cyc(1'b1, 16'h0205, 1'b0, 1'b1);
    n_cmp++;
    if ({state, wr_count, done, busy} !== {2'b00, 5'd5, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL abort: got state=%b wr=%0d done=%b busy=%b, required 00/5/0/0",
               state, wr_count, done, busy);
    end
    cyc(1'b1, 16'h0206, 1'b0, 1'b0);
    cyc(1'b1, 16'h0207, 1'b1, 1'b1);
    n_cmp++;
    if (state !== 2'b00 || wr_count !== 5'd5) begin
      n_bad++; $display("FAIL arm_abort: got state=%b wr=%0d, required 00/5", state, wr_count);
    end
  endtask

  task automatic test_full_depth;
    do_arm(1'b0, 16'd0, 8'd0, 5'd0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, DW'(100 + i), 1'b0, 1'b0);
      if (i < 16) exp_q.push_back(word(DW'(100 + i)));
      if (i == 14) begin
        n_cmp++;
        if (state !== 2'b10) begin
          n_bad++; $display("FAIL depth_mid: got state=%b, required 10", state);
        end
      end
    end
    n_cmp++;
    if (state !== 2'b11 || wr_count !== 5'd16) begin
      n_bad++; $display("FAIL depth_done: got state=%b wr=%0d, required 11/16", state, wr_count);
    end
    readback(16, "depth");
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_trigger_level();
    test_saturated_trigger();
    test_decimation();
    test_abort();
    test_full_depth();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL leftover: got %0d queued, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
